// File: rtl/escaneo_display_digitos.sv
// escaneo_display_digitos: freezes the operand digit bus once per frame and scans it onto a
// common-anode 7-segment display, with optional leading-zero blanking.
module escaneo_display_digitos #(
  parameter int N_DIGITS = 10,
  parameter int PRESCALE = 50000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [4*N_DIGITS-1:0]       digitos,
  input  logic                        blank_zeros,
  output logic [N_DIGITS-1:0]         an,
  output logic [6:0]                  seg,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_done
);
  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, top;
  logic [4*N_DIGITS-1:0] snap;
  logic tick, wrap, blank;
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction
  // highest non-zero digit of the frozen frame; digit 0 is always shown
  always_comb begin
    top = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (snap[4*i +: 4] != 4'd0) top = IW'(i);
  end
  assign tick      = cnt == CW'(PRESCALE - 1);
  assign wrap      = tick && idx == IW'(N_DIGITS - 1);
  assign blank     = blank_zeros && idx > top;
  assign digit_idx = idx;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= '0;
      snap       <= '0;
      an         <= '1;
      seg        <= 7'b1111111;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      idx        <= wrap ? '0 : tick ? idx + 1'b1 : idx;
      snap       <= wrap ? digitos : snap;
      frame_done <= wrap;
      an         <= blank ? '1 : ~(N_DIGITS'(1) << idx);
      seg        <= blank ? 7'b1111111 : decode(snap[4*idx +: 4]);
    end
  end
endmodule

// File: tb/tb_escaneo_display_digitos.sv
// tb_escaneo_display_digitos: scoreboard bench comparing two scan rates against a frame-level model.
module tb_escaneo_display_digitos;
  localparam int N  = 10;
  localparam int PA = 4;
  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         fd;
    logic [3:0]   di;
  } exp_t;
  logic clock = 0, reset = 0, blank_zeros = 1;
  logic [4*N-1:0] digitos = '0;
  logic [N-1:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic [3:0] di_a, di_b;
  logic fd_a, fd_b;
  int tests = 0, fails = 0, k = 0;
  logic [4*N-1:0] ms_a = '0, ms_b = '0;
  exp_t qa[$], qb[$];
  logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  escaneo_display_digitos #(.N_DIGITS(N), .PRESCALE(PA)) dut_a (
    .clock(clock), .reset(reset), .digitos(digitos), .blank_zeros(blank_zeros),
    .an(an_a), .seg(seg_a), .digit_idx(di_a), .frame_done(fd_a));
  escaneo_display_digitos #(.N_DIGITS(N), .PRESCALE(1)) dut_b (
    .clock(clock), .reset(reset), .digitos(digitos), .blank_zeros(blank_zeros),
    .an(an_b), .seg(seg_b), .digit_idx(di_b), .frame_done(fd_b));
  always #5 clock = ~clock;
  // expected outputs after the k-th edge since release: slot shown is the one active before that edge
  function automatic exp_t model(int kk, int p, logic [4*N-1:0] ms, logic bz);
    exp_t e;
    int slot = ((kk - 1) / p) % N;
    int top = 0;
    for (int i = 0; i < N; i++) if (ms[4*i +: 4] != 4'd0) top = i;
    e.fd = (kk % (N * p)) == 0;
    e.di = 4'((kk / p) % N);
    e.an = (bz && slot > top) ? '1 : ~(N'(1) << slot);
    e.seg = (bz && slot > top) ? 7'b1111111 : dec[ms[4*slot +: 4]];
    return e;
  endfunction
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      k = 0; ms_a = '0; ms_b = '0;
      qa.delete(); qb.delete();
    end else begin
      k++;
      qa.push_back(model(k, PA, ms_a, blank_zeros));
      qb.push_back(model(k, 1, ms_b, blank_zeros));
      if (k % (N * PA) == 0) ms_a = digitos;
      if (k % N == 0) ms_b = digitos;
    end
  end
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(negedge clock) begin
    exp_t ea, eb;
    if (!reset) begin
      chk("rst_an", 40'(an_a), 40'h3FF);
      chk("rst_seg", 40'(seg_a), 40'h7F);
      chk("rst_fd", 40'(fd_a), 40'h0);
      chk("rst_idx", 40'(di_a), 40'h0);
    end else if (qa.size() == 0 || qb.size() == 0) begin
      chk("queue_empty", 40'(qa.size()), 40'h1);
    end else begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("an_a", 40'(an_a), 40'(ea.an));
      chk("seg_a", 40'(seg_a), 40'(ea.seg));
      chk("fd_a", 40'(fd_a), 40'(ea.fd));
      chk("idx_a", 40'(di_a), 40'(ea.di));
      chk("an_b", 40'(an_b), 40'(eb.an));
      chk("seg_b", 40'(seg_b), 40'(eb.seg));
      chk("fd_b", 40'(fd_b), 40'(eb.fd));
      chk("idx_b", 40'(di_b), 40'(eb.di));
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #2;
  endtask
  initial begin
    logic [63:0] r;
    int nz;
    step(2);
    reset = 1;
    step(45);
    digitos = 40'h00_0000_1234;
    step(80);
    blank_zeros = 0;
    step(80);
    digitos = 40'hFE_DCBA_9876;
    step(80);
    digitos = 40'h1;
    step(N * PA - ((k + 1) % (N * PA)) + 5 * PA);
    digitos = 40'h2;
    step(80);
    blank_zeros = 1;
    step(N * PA - ((k + 1) % (N * PA)) + 7 * PA + 1);
    reset = 0;
    step(1);
    reset = 1;
    step(60);
    for (int it = 0; it < 25; it++) begin
      r = {$urandom(), $urandom()};
      digitos = r[39:0];
      nz = $urandom_range(0, N);
      for (int j = nz; j < N; j++) digitos[4*j +: 4] = 4'd0;
      blank_zeros = 1'($urandom_range(0, 1));
      step($urandom_range(1, 60));
    end
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/escaneo_display_digitos.md
# escaneo_display_digitos

Read side of the calculator operand digit registers. Takes the 40-bit packed digit bus produced by an operand register (10 hex digits, digit 0 in bits [3:0]), freezes it once per scan frame, and time-multiplexes it onto a common-anode 7-segment display with optional leading-zero blanking. Sits between the operand/result registers and the board display pins.

## Interface
- N_DIGITS, 10, number of displayed digits; digit bus width is 4*N_DIGITS.
- PRESCALE, 50000, clock cycles per digit slot; must be >= 1.

- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- digitos  in  4*N_DIGITS  packed hex digits; digit i in bits [4i+3:4i].
- blank_zeros  in  1  1 = suppress leading zero digits.
- an  out  N_DIGITS  anode enables, active-low, one-hot-low or all high.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- digit_idx  out  $clog2(N_DIGITS)  index of the slot currently in the state registers.
- frame_done  out  1  one-cycle pulse, once per completed scan frame.

## Operation
- Prescaler cnt counts 0..PRESCALE-1; tick = (cnt == PRESCALE-1); on tick cnt returns to 0.
- Slot index idx advances by 1 on each tick; at N_DIGITS-1 it wraps to 0.
- Wrap tick (idx == N_DIGITS-1 and tick): snap <= digitos, frame_done <= 1 for the next cycle only. digitos is ignored at all other times; changes mid-frame never tear the displayed value.
- Leading-digit boundary: top = highest i with snap digit i != 0, 0 if snap is all zero.
- Digit i is blanked when blank_zeros = 1 and i > top. Digit 0 is never blanked (a zero value shows "0"). blank_zeros is sampled combinationally each cycle, no frame latency.
- Output register, loaded every cycle from (idx, snap, blank_zeros):
  - not blanked: an = all ones except bit idx = 0; seg = decode(snap digit idx).
  - blanked: an = all ones; seg = 7'b1111111.
- Decode (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- digit_idx = idx, unregistered copy.

## Timing
- Reset (reset = 0, asynchronous): cnt = 0, idx = 0, snap = 0, an = all ones, seg = 7'b1111111, frame_done = 0.
- First rising edge after release: an/seg show slot 0 of snap = 0 (an bit 0 low, seg = 1000000).
- an/seg lag idx/snap by exactly one cycle; digit_idx leads an by one cycle.
- Each slot is displayed for PRESCALE cycles; one frame = N_DIGITS*PRESCALE cycles.
- New digitos values are visible on the display no sooner than the cycle after the wrap tick and no later than N_DIGITS*PRESCALE+1 cycles after they are applied.
- PRESCALE = 1: tick on every cycle, idx advances every cycle, frame_done pulses every N_DIGITS cycles.
- Reset asserted mid-frame: all state returns to reset values immediately. The interrupted frame never produces frame_done. The snapshot is not reloaded until the next full frame.
- No other inputs are sampled on edges; there is no handshake.

## Test plan
- Reset release, PRESCALE=4, digitos=0, blank_zeros=1 -> an=3FE, seg=1000000 one cycle after release; every slot i>0 shows an=3FF, seg=7F; frame_done first pulses 40 cycles after release.
- digitos=40'h00_0000_1234, blank_zeros=1, over one frame -> slots 0..3 show 4,3,2,1 (0011001, 0110000, 0100100, 1111001) with an bits 0..3 low in turn; slots 4..9 show an=3FF.
- Same value with blank_zeros=0 -> slots 4..9 show seg=1000000 with their own anode low.
- digitos=40'hFEDCBA9876, blank_zeros=0 -> every decode entry from 6 to F appears in its slot.
- Change digitos from 40'h1 to 40'h2 at slot 5 -> the rest of the frame still shows 1; the next frame shows 2 in slot 0.
- Assert reset for 1 cycle at slot 7 -> outputs go to all-high immediately; no frame_done occurs for the aborted frame; the scan restarts at slot 0.
